gate_truth_checker: RTL and testbench

GATE_TRUTH_CHECKER -- requirements
Module: gate_truth_checker

---
 rtl/gate_truth_checker.sv | 98 +++++++++
 tb/tb_gate_truth_checker.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_checker.sv
// Drives all four {a,b} vectors into an external 2-input gate, waits SETTLE
// cycles per vector, samples y_in and records mismatches against EXPECTED.
module gate_truth_checker #(
   parameter logic [3:0]  EXPECTED = 4'b0111,
   parameter int unsigned SETTLE   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       y_in,
   output logic       a_out,
   output logic       b_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_mask,
   output logic [2:0] err_count
);

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

   localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

   state_t     state;
   state_t     state_nxt;
   logic [1:0] idx;
   logic [3:0] cnt;
   logic       launch;
   logic       mismatch;

   assign launch   = ((state == IDLE) || (state == DONE)) && start;
   assign mismatch = (y_in != EXPECTED[idx]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (start) state_nxt = DRIVE;
         DRIVE:      if (cnt == '0) state_nxt = SAMPLE;
         SAMPLE:     state_nxt = (idx == 2'd3) ? DONE : DRIVE;
         default:    state_nxt = IDLE;
      endcase
   end

   // The drive vector is loaded together with idx so a_out/b_out are already
   // stable on the first DRIVE cycle and stay at 2'b11 through DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx       <= '0;
         cnt       <= '0;
         a_out     <= 1'b0;
         b_out     <= 1'b0;
         fail_mask <= '0;
         err_count <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (launch) begin
                  idx            <= '0;
                  cnt            <= RELOAD;
                  {a_out, b_out} <= 2'b00;
                  fail_mask      <= '0;
                  err_count      <= '0;
               end
            end
            DRIVE: begin
               if (cnt != '0) cnt <= cnt - 4'd1;
            end
            SAMPLE: begin
               if (mismatch) begin
                  fail_mask[idx] <= 1'b1;
                  err_count      <= err_count + 3'd1;
               end
               if (idx != 2'd3) begin
                  idx            <= idx + 2'd1;
                  {a_out, b_out} <= idx + 2'd1;
                  cnt            <= RELOAD;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      busy = (state == DRIVE) || (state == SAMPLE);
      done = (state == DONE);
      pass = (state == DONE) && (fail_mask == '0);
   end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Checks two checker instances (SETTLE=2 and SETTLE=1) against a run-position
// model driven by simulated gates (NAND, AND, tied-1, tied-0).
module tb_gate_truth_checker;

   typedef struct packed {
      logic       active;
      logic       done;
      logic [3:0] mask;
      logic [1:0] ab;
      logic [7:0] t;
   } model_t;

   localparam logic [1:0] M_NAND = 2'd0;
   localparam logic [1:0] M_AND  = 2'd1;
   localparam logic [1:0] M_ONE  = 2'd2;
   localparam logic [1:0] M_ZERO = 2'd3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start0 = 1'b0, start1 = 1'b0;
   logic [1:0] mode0 = M_NAND, mode1 = M_NAND;
   logic       y0, y1, a0, b0, a1, b1;
   logic       busy0, done0, pass0, busy1, done1, pass1;
   logic [3:0] fm0, fm1;
   logic [2:0] ec0, ec1;
   model_t     m0 = '0, m1 = '0;
   int         total = 0;
   int         passed = 0;

   always #5 clk = ~clk;

   function automatic logic gate_y(input logic [1:0] mode, input logic [1:0] ab);
      case (mode)
         M_NAND:  return ~(ab[1] & ab[0]);
         M_AND:   return ab[1] & ab[0];
         M_ONE:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   always_comb y0 = gate_y(mode0, {a0, b0});
   always_comb y1 = gate_y(mode1, {a1, b1});

   gate_truth_checker #(.EXPECTED(4'b0111), .SETTLE(2)) u_dut0 (
      .clk(clk), .rst(rst), .start(start0), .y_in(y0), .a_out(a0), .b_out(b0),
      .busy(busy0), .done(done0), .pass(pass0), .fail_mask(fm0), .err_count(ec0));

   gate_truth_checker #(.EXPECTED(4'b0111), .SETTLE(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .y_in(y1), .a_out(a1), .b_out(b1),
      .busy(busy1), .done(done1), .pass(pass1), .fail_mask(fm1), .err_count(ec1));

   // A run is 4*(settle+1) cycles; vector v occupies positions v*(settle+1)..,
   // its last position is the sample point, judged against a NAND truth table.
   function automatic model_t step(input model_t s, input int settle,
                                   input logic st, input logic y);
      model_t n;
      int     v, ph;
      n = s;
      if (s.active) begin
         v  = int'(s.t) / (settle + 1);
         ph = int'(s.t) % (settle + 1);
         if (ph == settle) begin
            if (y != gate_y(M_NAND, 2'(v))) n.mask[v] = 1'b1;
            if (v == 3) begin
               n.active = 1'b0;
               n.done   = 1'b1;
            end else begin
               n.ab = 2'(v + 1);
            end
         end
         n.t = s.t + 8'd1;
      end else if (st) begin
         n        = '0;
         n.active = 1'b1;
      end
      return n;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m0 <= '0;
         m1 <= '0;
      end else begin
         m0 <= step(m0, 2, start0, gate_y(mode0, m0.ab));
         m1 <= step(m1, 1, start1, gate_y(mode1, m1.ab));
      end
   end

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act == req) passed++;
      else $display("FAIL %s actual=%0d required=%0d", name, act, req);
   endtask

   always @(negedge clk) begin
      chk("busy0", int'(busy0), int'(m0.active));
      chk("done0", int'(done0), int'(m0.done));
      chk("pass0", int'(pass0), int'(m0.done && m0.mask == 4'd0));
      chk("mask0", int'(fm0), int'(m0.mask));
      chk("err0", int'(ec0), $countones(m0.mask));
      chk("ab0", int'({a0, b0}), int'(m0.ab));
      chk("busy1", int'(busy1), int'(m1.active));
      chk("done1", int'(done1), int'(m1.done));
      chk("pass1", int'(pass1), int'(m1.done && m1.mask == 4'd0));
      chk("mask1", int'(fm1), int'(m1.mask));
      chk("err1", int'(ec1), $countones(m1.mask));
      chk("ab1", int'({a1, b1}), int'(m1.ab));
   end

   task automatic wait_done0(input int repulse, output int bc);
      bit ok;
      ok = 1'b0;
      bc = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #1;
         start0 = (i == repulse);
         if (busy0) bc++;
         if (done0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("timeout_done0", 0, 1);
   endtask

   task automatic run0(input logic [1:0] mode, input int repulse,
                       input bit release_rst, output int bc);
      @(negedge clk);
      #1;
      mode0  = mode;
      start0 = 1'b1;
      if (release_rst) rst = 1'b0;
      wait_done0(repulse, bc);
   endtask

   task automatic chk_res0(input string tag, input int mask, input int err, input int ps);
      chk({tag, "_done"}, int'(done0), 1);
      chk({tag, "_mask"}, int'(fm0), mask);
      chk({tag, "_err"}, int'(ec0), err);
      chk({tag, "_pass"}, int'(pass0), ps);
      chk({tag, "_model_mask"}, int'(m0.mask), mask);
   endtask

   initial begin
      int         bc;
      bit         hit;
      logic [1:0] seq [8];
      logic [1:0] exp_seq [8];
      exp_seq = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};

      repeat (2) @(negedge clk);
      #1;
      chk("rst_busy", int'(busy0), 0);
      chk("rst_done", int'(done0), 0);
      chk("rst_mask", int'(fm0), 0);
      chk("rst_ab", int'({a0, b0}), 0);

      // NAND gate, SETTLE=2: 12 busy cycles, clean pass
      run0(M_NAND, -1, 1'b1, bc);
      chk("nand_busy_cycles", bc, 12);
      chk_res0("nand", 0, 0, 1);

      run0(M_ONE, -1, 1'b0, bc);
      chk_res0("tie1", 4'b1000, 1, 0);

      // AND gate, with a start pulse mid-run that must be ignored
      run0(M_AND, 5, 1'b0, bc);
      chk("and_busy_cycles", bc, 12);
      chk_res0("and", 4'b1111, 4, 0);

      run0(M_ZERO, -1, 1'b0, bc);
      chk_res0("tie0", 4'b0111, 3, 0);
      repeat (3) @(negedge clk);
      #1;
      chk("tie0_hold_mask", int'(fm0), 4'b0111);
      chk("tie0_hold_err", int'(ec0), 3);

      // restart from DONE clears results on the entering edge
      mode0  = M_NAND;
      start0 = 1'b1;
      @(negedge clk);
      #1;
      start0 = 1'b0;
      chk("restart_busy", int'(busy0), 1);
      chk("restart_done", int'(done0), 0);
      chk("restart_mask", int'(fm0), 0);
      chk("restart_err", int'(ec0), 0);
      wait_done0(-1, bc);
      chk_res0("renand", 0, 0, 1);

      // async reset during the third vector's DRIVE
      @(negedge clk);
      #1;
      mode0  = M_ZERO;
      start0 = 1'b1;
      hit    = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         #1;
         start0 = 1'b0;
         if (busy0 && {a0, b0} == 2'b10) begin
            hit = 1'b1;
            break;
         end
      end
      chk("third_vector_reached", int'(hit), 1);
      chk("partial_mask", int'(fm0), 4'b0011);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", int'(busy0), 0);
      chk("arst_ab", int'({a0, b0}), 0);
      chk("arst_mask", int'(fm0), 0);
      chk("arst_err", int'(ec0), 0);
      chk("arst_done", int'(done0), 0);
      run0(M_NAND, -1, 1'b1, bc);
      chk("post_rst_busy_cycles", bc, 12);
      chk_res0("post_rst", 0, 0, 1);

      // SETTLE=1 with start held high: 2 cycles per vector, then restart
      @(negedge clk);
      #1;
      mode1  = M_NAND;
      start1 = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         #1;
         seq[k] = {a1, b1};
         chk("held_busy", int'(busy1), 1);
      end
      for (int k = 0; k < 8; k++) chk("held_vec_order", int'(seq[k]), int'(exp_seq[k]));
      @(negedge clk);
      #1;
      chk("held_done", int'(done1), 1);
      chk("held_pass", int'(pass1), 1);
      chk("held_done_ab", int'({a1, b1}), 3);
      @(negedge clk);
      #1;
      start1 = 1'b0;
      chk("held_restart_busy", int'(busy1), 1);
      chk("held_restart_ab", int'({a1, b1}), 0);
      hit = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         #1;
         if (done1) begin
            hit = 1'b1;
            break;
         end
      end
      chk("held_second_done", int'(hit), 1);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
